// File: rtl/adder_tree_acc_if.sv
// Beat-in / packet-sum-out handshake bundle for adder_tree_acc.
// master = the environment (upstream source plus downstream sink), slave = the block.
interface adder_tree_acc_if #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int AW = 8
);
    localparam int OW = W + $clog2(N) + AW;

    logic            I_VALID;
    logic            O_READY;
    logic [N*W-1:0]  I_DATA;
    logic            I_LAST;
    logic            O_VALID;
    logic            I_READY;
    logic [OW-1:0]   O_SUM;

    modport master (
        output I_VALID, I_DATA, I_LAST, I_READY,
        input  O_READY, O_VALID, O_SUM
    );

    modport slave (
        input  I_VALID, I_DATA, I_LAST, I_READY,
        output O_READY, O_VALID, O_SUM
    );
endinterface

// File: rtl/adder_tree_acc.sv
// Pipelined N-lane adder tree feeding a packet accumulator.
// The tree is held as a heap: node i has children 2i and 2i+1, leaves P..2P-1
// are the extended input lanes, internal nodes 1..P-1 are registered, so a
// beat reaches the root after S = clog2(N) edges. One global enable stalls
// the whole pipe whenever the output register is full and not being taken.
module adder_tree_acc #(
    parameter int W      = 16,
    parameter int N      = 4,
    parameter int AW     = 8,
    parameter int SIGNED = 0
) (
    input logic          I_CLK,
    input logic          I_RST_N,
    adder_tree_acc_if.slave bus
);
    localparam int S  = $clog2(N);
    localparam int P  = 1 << S;
    // Every tree node is kept at the final tree width; the sum of P lanes
    // always fits, so lower stages simply carry redundant top bits.
    localparam int TW = W + S;
    localparam int OW = W + S + AW;

    logic            en;
    logic            accept;
    logic [P*W-1:0]  data_pad;
    logic [W-1:0]    lane;
    logic [TW-1:0]   node_v [2:2*P-1];
    logic [TW-1:0]   node_d [1:P-1];
    logic [TW-1:0]   node_q [1:P-1];
    logic [S:1]      vld_pipe;
    logic [S:1]      last_pipe;
    logic [OW-1:0]   tree_ext;
    logic [OW-1:0]   sum_next;
    logic [OW-1:0]   acc;
    logic            first;
    logic            out_vld;
    logic [OW-1:0]   out_sum;

    assign en          = !out_vld || bus.I_READY;
    assign accept      = bus.I_VALID && en;
    assign bus.O_READY = en;
    assign bus.O_VALID = out_vld;
    assign bus.O_SUM   = out_sum;

    // Extend lanes (padding lanes are zero, so they add nothing) and form
    // the next value of every internal tree node.
    always_comb begin
        data_pad = '0;
        data_pad[N*W-1:0] = bus.I_DATA;
        lane = '0;
        for (int i = 2; i < P; i++) node_v[i] = node_q[i];
        for (int k = 0; k < P; k++) begin
            lane = data_pad[k*W +: W];
            node_v[P+k] = {TW{(SIGNED != 0) && lane[W-1]}};
            node_v[P+k][W-1:0] = lane;
        end
        for (int i = 1; i < P; i++) node_d[i] = node_v[2*i] + node_v[2*i+1];
    end

    // Root extended to the output width, then added onto the running total.
    always_comb begin
        tree_ext = {OW{(SIGNED != 0) && node_q[1][TW-1]}};
        tree_ext[TW-1:0] = node_q[1];
        sum_next = (first ? '0 : acc) + tree_ext;
    end

    // Tree registers with their valid/last shift registers; all hold on stall.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int i = 1; i < P; i++) node_q[i] <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else if (en) begin
            for (int i = 1; i < P; i++) node_q[i] <= node_d[i];
            vld_pipe[1]  <= accept;
            last_pipe[1] <= bus.I_LAST;
            for (int s = 2; s <= S; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                last_pipe[s] <= last_pipe[s-1];
            end
        end
    end

    // Packet accumulator; the last beat publishes the total and rearms 'first'.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            acc     <= '0;
            first   <= 1'b1;
            out_vld <= 1'b0;
            out_sum <= '0;
        end else if (en) begin
            if (vld_pipe[S]) begin
                if (last_pipe[S]) begin
                    out_sum <= sum_next;
                    out_vld <= 1'b1;
                    acc     <= '0;
                    first   <= 1'b1;
                end else begin
                    acc     <= sum_next;
                    first   <= 1'b0;
                    out_vld <= 1'b0;
                end
            end else begin
                out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc across four configurations:
// d0 W16 N4 unsigned, d1 W8 N4 signed, d2 W16 N3, d3 W16 N3 AW1.
module tb_adder_tree_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_tree_acc_if #(.W(16), .N(4), .AW(8)) if0 ();
    adder_tree_acc_if #(.W(8),  .N(4), .AW(8)) if1 ();
    adder_tree_acc_if #(.W(16), .N(3), .AW(8)) if2 ();
    adder_tree_acc_if #(.W(16), .N(3), .AW(1)) if3 ();

    adder_tree_acc #(.W(16), .N(4), .AW(8), .SIGNED(0)) u0 (.I_CLK(clk), .I_RST_N(rst_n), .bus(if0));
    adder_tree_acc #(.W(8),  .N(4), .AW(8), .SIGNED(1)) u1 (.I_CLK(clk), .I_RST_N(rst_n), .bus(if1));
    adder_tree_acc #(.W(16), .N(3), .AW(8), .SIGNED(0)) u2 (.I_CLK(clk), .I_RST_N(rst_n), .bus(if2));
    adder_tree_acc #(.W(16), .N(3), .AW(1), .SIGNED(0)) u3 (.I_CLK(clk), .I_RST_N(rst_n), .bus(if3));

    typedef struct {
        int                d;
        logic [3:0][15:0]  lanes;
        logic [25:0]       exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input logic [15:0] l3, input logic [15:0] l2,
                                input logic [15:0] l1, input logic [15:0] l0, input logic [25:0] e);
        vec_t v;
        v.d = d;
        v.lanes = {l3, l2, l1, l0};
        v.exp = e;
        return v;
    endfunction

    // Present one cycle of input on DUT d (others idle), then advance to next negedge.
    task automatic drive(input int d, input logic [3:0][15:0] l, input logic last, input logic valid);
        if0.I_VALID = 1'b0; if1.I_VALID = 1'b0; if2.I_VALID = 1'b0; if3.I_VALID = 1'b0;
        case (d)
            0: begin if0.I_DATA = l; if0.I_LAST = last; if0.I_VALID = valid; end
            1: begin if1.I_DATA = {l[3][7:0], l[2][7:0], l[1][7:0], l[0][7:0]};
                     if1.I_LAST = last; if1.I_VALID = valid; end
            2: begin if2.I_DATA = {l[2], l[1], l[0]}; if2.I_LAST = last; if2.I_VALID = valid; end
            default: begin if3.I_DATA = {l[2], l[1], l[0]}; if3.I_LAST = last; if3.I_VALID = valid; end
        endcase
        @(negedge clk);
    endtask

    task automatic get(input int d, output logic v, output logic [25:0] s, output logic r);
        case (d)
            0: begin v = if0.O_VALID; s = 26'(if0.O_SUM); r = if0.O_READY; end
            1: begin v = if1.O_VALID; s = 26'(if1.O_SUM); r = if1.O_READY; end
            2: begin v = if2.O_VALID; s = 26'(if2.O_SUM); r = if2.O_READY; end
            default: begin v = if3.O_VALID; s = 26'(if3.O_SUM); r = if3.O_READY; end
        endcase
    endtask

    // Called right after the closing beat was driven: expects the sum two
    // idle cycles later (S+1 after accept), held for exactly one cycle.
    task automatic wait_sum(input int d, input string nm, input logic [25:0] exp);
        int cnt;
        logic v, r;
        logic [25:0] s;
        cnt = 0;
        get(d, v, s, r);
        while (!v && cnt < 10) begin
            drive(d, '0, 1'b0, 1'b0);
            cnt++;
            get(d, v, s, r);
        end
        check({nm, " valid"}, 32'(v), 32'd1);
        check({nm, " sum"}, 32'(s), 32'(exp));
        check({nm, " latency"}, 32'(cnt), 32'd2);
        drive(d, '0, 1'b0, 1'b0);
        get(d, v, s, r);
        check({nm, " single pulse"}, 32'(v), 32'd0);
    endtask

    vec_t vecs[10];
    logic v, r, rdy, hold;
    logic [25:0] s, prev_sum;
    logic [3:0][15:0] ones, twos, accb, big3;
    logic [3:0][15:0] pk[4];
    logic [25:0] pk_exp[4];
    logic [25:0] q[$];
    int idx, got, pulses, stalls;

    initial begin
        vecs[0] = mk(0, 16'd4, 16'd3, 16'd2, 16'd1, 26'd10);
        vecs[1] = mk(0, 16'd1, 16'd1, 16'd1, 16'd1, 26'd4);
        vecs[2] = mk(0, 16'd2, 16'd2, 16'd2, 16'd2, 26'd8);
        vecs[3] = mk(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 26'd262140);
        vecs[4] = mk(1, 16'h0005, 16'h007F, 16'h0080, 16'h00FF, 26'h00003);
        vecs[5] = mk(1, 16'h0080, 16'h0080, 16'h0080, 16'h0080, 26'h3FE00);
        vecs[6] = mk(1, 16'h007F, 16'h007F, 16'h007F, 16'h007F, 26'd508);
        vecs[7] = mk(2, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 26'd196605);
        vecs[8] = mk(3, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 26'd196605);
        vecs[9] = mk(0, 16'd0, 16'd0, 16'd0, 16'd0, 26'd0);
        ones = {16'd1, 16'd1, 16'd1, 16'd1};
        twos = {16'd2, 16'd2, 16'd2, 16'd2};
        accb = {16'd400, 16'd300, 16'd200, 16'd100};
        big3 = {16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF};

        if0.I_VALID = 0; if0.I_DATA = '0; if0.I_LAST = 0; if0.I_READY = 1;
        if1.I_VALID = 0; if1.I_DATA = '0; if1.I_LAST = 0; if1.I_READY = 1;
        if2.I_VALID = 0; if2.I_DATA = '0; if2.I_LAST = 0; if2.I_READY = 1;
        if3.I_VALID = 0; if3.I_DATA = '0; if3.I_LAST = 0; if3.I_READY = 1;

        // Reset state on all four instances.
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            get(d, v, s, r);
            check($sformatf("reset d%0d valid", d), 32'(v), 32'd0);
            check($sformatf("reset d%0d sum", d), 32'(s), 32'd0);
            check($sformatf("reset d%0d ready", d), 32'(r), 32'd1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Single-beat packets from the table.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].d, vecs[i].lanes, 1'b1, 1'b1);
            wait_sum(vecs[i].d, $sformatf("vec%0d", i), vecs[i].exp);
        end

        // Back-to-back single-beat packets come out on consecutive cycles.
        drive(0, ones, 1'b1, 1'b1);
        drive(0, twos, 1'b1, 1'b1);
        drive(0, '0, 1'b0, 1'b0);
        get(0, v, s, r);
        check("b2b first valid", 32'(v), 32'd1);
        check("b2b first sum", 32'(s), 32'd4);
        drive(0, '0, 1'b0, 1'b0);
        get(0, v, s, r);
        check("b2b second valid", 32'(v), 32'd1);
        check("b2b second sum", 32'(s), 32'd8);
        drive(0, '0, 1'b0, 1'b0);
        get(0, v, s, r);
        check("b2b drained", 32'(v), 32'd0);

        // Three-beat packet with a bubble: exactly one output pulse of 3000.
        pulses = 0;
        prev_sum = '0;
        for (int c = 0; c < 12; c++) begin
            case (c)
                0, 2:    drive(0, accb, 1'b0, 1'b1);
                3:       drive(0, accb, 1'b1, 1'b1);
                default: drive(0, '0, 1'b0, 1'b0);
            endcase
            get(0, v, s, r);
            if (v) begin pulses++; prev_sum = s; end
        end
        check("acc pulses", 32'(pulses), 32'd1);
        check("acc sum", 32'(prev_sum), 32'd3000);

        // Narrow headroom wraps modulo 2**19.
        drive(3, big3, 1'b0, 1'b1);
        drive(3, big3, 1'b0, 1'b1);
        drive(3, big3, 1'b1, 1'b1);
        wait_sum(3, "aw1 wrap", 26'd65527);

        // Backpressure: 4 single-beat packets, I_READY low for 5 cycles.
        for (int i = 0; i < 4; i++) begin
            pk_exp[i] = '0;
            for (int k = 0; k < 4; k++) begin
                pk[i][k] = 16'($urandom_range(0, 65535));
                pk_exp[i] = pk_exp[i] + 26'(pk[i][k]);
            end
        end
        idx = 0; got = 0; hold = 0; stalls = 0; prev_sum = '0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            rdy = !(c >= 2 && c < 7);
            if0.I_READY = rdy;
            if (idx < 4) begin
                if0.I_DATA = pk[idx]; if0.I_LAST = 1'b1; if0.I_VALID = 1'b1;
            end else begin
                if0.I_VALID = 1'b0;
            end
            #1;
            get(0, v, s, r);
            check("bp ready", 32'(r), 32'(!v || rdy));
            if (!r) stalls++;
            if (hold) begin
                check("bp hold valid", 32'(v), 32'd1);
                check("bp hold sum", 32'(s), 32'(prev_sum));
            end
            if (v && rdy) begin
                if (q.size() == 0) begin
                    check("bp duplicate output", 32'd1, 32'(q.size()));
                end else begin
                    check($sformatf("bp sum%0d", got), 32'(s), 32'(q.pop_front()));
                    got++;
                end
            end
            if (if0.I_VALID && r) begin
                q.push_back(pk_exp[idx]);
                idx++;
            end
            hold = v && !rdy;
            prev_sum = s;
            @(negedge clk);
        end
        if0.I_VALID = 1'b0;
        if0.I_READY = 1'b1;
        check("bp received", 32'(got), 32'd4);
        check("bp sent", 32'(idx), 32'd4);
        check("bp stalled", 32'(stalls > 0), 32'd1);

        // Reset mid-packet discards the partial sum and in-flight beats.
        drive(0, ones, 1'b0, 1'b1);
        drive(0, ones, 1'b0, 1'b1);
        if0.I_VALID = 1'b0;
        rst_n = 1'b0;
        #1;
        get(0, v, s, r);
        check("rst valid", 32'(v), 32'd0);
        check("rst sum", 32'(s), 32'd0);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        drive(0, ones, 1'b1, 1'b1);
        wait_sum(0, "post-rst", 26'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
